// File: rtl/image_processor_config_sequencer.sv
// image_processor_config_sequencer
// Stages control/brightness/contrast register writes from the AXI-lite
// register file and commits them to image_processor only at frame_start, so
// no frame ever sees mixed settings. Brightness can optionally ramp toward
// its target by C_RAMP_STEP per frame.
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   reg_control_in        control word (passed through whole)
//   reg_brightness_in     [8:0] signed brightness target
//   reg_contrast_in       [7:0] contrast, 4.4 unsigned
//   update_req            pulse: software finished writing the config
//   ramp_en               1 = ramp brightness, 0 = apply directly
//   frame_start           pulse at first pixel of a frame
//   register_control      applied control word
//   register_brightness   applied brightness, sign-extended
//   register_contrast     applied contrast, zero-extended
//   update_pending        staged config waiting for frame_start
//   ramp_busy             applied brightness != target
//   config_committed      one-cycle pulse after a commit
//   frame_count           frame_start pulses since reset (wraps)
module image_processor_config_sequencer #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_RAMP_STEP        = 8,
    parameter int C_FRAME_CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] reg_control_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] reg_brightness_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] reg_contrast_in,
    input  logic                          update_req,
    input  logic                          ramp_en,
    input  logic                          frame_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0] register_control,
    output logic [C_S_AXI_DATA_WIDTH-1:0] register_brightness,
    output logic [C_S_AXI_DATA_WIDTH-1:0] register_contrast,
    output logic                          update_pending,
    output logic                          ramp_busy,
    output logic                          config_committed,
    output logic [C_FRAME_CNT_WIDTH-1:0]  frame_count
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [DW-1:0]      CTRL_RST = DW'(32'h10);   // bypass
    localparam logic [7:0]         CON_RST  = 8'h10;         // gain 1.0
    localparam logic signed [9:0]  STEP10   = 10'(C_RAMP_STEP);
    localparam logic signed [9:0]  NSTEP10  = -STEP10;
    localparam logic [8:0]         STEP9    = 9'(C_RAMP_STEP);

    // State bits are {pending, ramping}
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        RAMP       = 2'b01,
        ARMED      = 2'b10,
        RAMP_ARMED = 2'b11
    } state_t;

    typedef struct packed {
        logic [DW-1:0]     control;
        logic signed [8:0] bright;
        logic [7:0]        contrast;
    } cfg_t;

    state_t                 state;
    cfg_t                   stg;
    logic [DW-1:0]          control_q;
    logic [7:0]             contrast_q;
    logic signed [8:0]      target_q;
    logic signed [8:0]      applied_q;
    logic                   committed_q;
    logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    logic signed [8:0]      bright_clamped;
    logic                   commit;
    logic signed [8:0]      next_target;
    logic signed [9:0]      diff;
    logic signed [8:0]      stepped;
    logic signed [8:0]      new_applied;
    logic                   pending_n;
    logic                   ramping_n;
    logic                   unused_bits;

    // -256 has no positive counterpart; clamp so the range is symmetric
    assign bright_clamped = (reg_brightness_in[8:0] == 9'h100) ? 9'sh101
                                                               : reg_brightness_in[8:0];

    assign commit      = frame_start & state[1];
    assign next_target = commit ? stg.bright : target_q;

    // Distance to the (possibly freshly committed) target, one bit wider
    // so the full -255..255 span cannot overflow
    assign diff = {next_target[8], next_target} - {applied_q[8], applied_q};

    always_comb begin
        stepped = next_target;
        if (diff > STEP10)
            stepped = applied_q + STEP9;
        else if (diff < NSTEP10)
            stepped = applied_q - STEP9;
    end

    assign new_applied = ramp_en ? stepped : next_target;

    // A simultaneous update_req re-arms for the next frame; the commit on
    // this edge still uses the old staging contents.
    assign pending_n = update_req | (state[1] & ~frame_start);
    assign ramping_n = frame_start ? (new_applied != next_target) : state[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stg.control  <= CTRL_RST;
            stg.bright   <= '0;
            stg.contrast <= CON_RST;
            control_q    <= CTRL_RST;
            contrast_q   <= CON_RST;
            target_q     <= '0;
            applied_q    <= '0;
            committed_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            committed_q <= commit;
            state       <= state_t'({pending_n, ramping_n});
            if (update_req) begin
                stg.control  <= reg_control_in;
                stg.bright   <= bright_clamped;
                stg.contrast <= reg_contrast_in[7:0];
            end
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if (commit) begin
                    control_q  <= stg.control;
                    contrast_q <= stg.contrast;
                    target_q   <= stg.bright;
                end
                if (state != IDLE)
                    applied_q <= new_applied;
            end
        end
    end

    assign register_control    = control_q;
    assign register_brightness = {{(DW-9){applied_q[8]}}, applied_q};
    assign register_contrast   = {{(DW-8){1'b0}}, contrast_q};
    assign update_pending      = state[1];
    assign ramp_busy           = (applied_q != target_q);
    assign config_committed    = committed_q;
    assign frame_count         = frame_cnt_q;

    assign unused_bits = ^{reg_brightness_in[DW-1:9], reg_contrast_in[DW-1:8]};

endmodule
